countdown_monitor: RTL and testbench

//  Downstream consumer of the free-running N-bit down counter. Samples its count

---
 rtl/countdown_monitor.sv | 152 +++++++++++++++
 tb/tb_countdown_monitor.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_monitor.sv
// countdown_monitor
// Watches a free-running N-bit down counter coming from another block. On every
// rising edge it does four things:
//   - samples the count,
//   - flags a wrap from 0 to all-ones,
//   - checks that the count dropped by exactly one,
//   - counts wraps in an armable FSM that raises a held alarm at a threshold.
// Every output comes straight from a flop. An input change shows up on the
// outputs one cycle later, and no input reaches an output combinationally.

`timescale 1ns/1ps

module countdown_monitor #(
  parameter int N = 5,  // width of count_in, must match the upstream counter
  parameter int P = 8   // width of the period counter and the threshold
) (
  input  logic         clk,
  input  logic         reset,       // asynchronous, active-high
  input  logic [N-1:0] count_in,
  input  logic         arm,
  input  logic [P-1:0] threshold,   // 0 means never alarm; held stable while armed
  input  logic         alarm_ack,
  output logic         wrap_pulse,
  output logic [P-1:0] period_cnt,
  output logic         alarm,
  output logic         seq_err,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_ALARM = 2'b10
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [N-1:0] count_q, count_d;           // previous sample of count_in
  logic         valid_q, valid_d;           // count_q holds a real sample
  logic         wrap_pulse_q, wrap_pulse_d;
  logic [P-1:0] period_cnt_q, period_cnt_d;
  logic         alarm_q, alarm_d;
  logic         seq_err_q, seq_err_d;
  state_e       state_q, state_d;

  // ---------------------------------------------------------------------------
  // Per-edge observations of the upstream counter
  // ---------------------------------------------------------------------------
  logic [N-1:0] count_dec;    // the value count_in must take on this edge
  logic         wrap_det;     // this edge sees 0 -> all-ones
  logic         step_bad;     // this edge sees anything but a single decrement
  logic [P-1:0] period_inc;   // the period count plus this wrap, mod 2^P

  assign count_dec  = count_q - 1'b1;
  // A wrap also passes the step check, because 0 - 1 mod 2^N is all-ones.
  assign wrap_det   = valid_q && (count_q == '0) && (count_in == '1);
  // A stall, where count_in equals count_q, is caught here too.
  assign step_bad   = valid_q && (count_in != count_dec);
  assign period_inc = period_cnt_q + 1'b1;

  // Sample path: capture the count, and turn detections into a one-cycle wrap
  // flag and a sticky sequence-error flag.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path through the block can leave it unassigned and infer a latch.
    count_d      = count_in;
    valid_d      = 1'b1;
    wrap_pulse_d = wrap_det;
    seq_err_d    = seq_err_q | step_bad;
  end

  // Wrap-counting FSM: next state and next period count.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;

    case (state_q)
      ST_IDLE: begin
        period_cnt_d = '0;
        if (arm) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (!arm) begin
          // Disarming wins over a wrap on the same edge.
          state_d      = ST_IDLE;
          period_cnt_d = '0;
        end else if (wrap_det) begin
          period_cnt_d = period_inc;
          if ((threshold != '0) && (period_inc == threshold)) begin
            state_d = ST_ALARM;
          end
        end
      end

      ST_ALARM: begin
        // Wraps are ignored here. A wrap that lands on the ack edge is dropped,
        // because the count restarts from zero.
        if (alarm_ack) begin
          period_cnt_d = '0;
          state_d      = arm ? ST_ARMED : ST_IDLE;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        period_cnt_d = '0;
      end
    endcase
  end

  // The alarm flop follows the next state, so alarm and state change together.
  always_comb begin
    alarm_d = (state_d == ST_ALARM);
  end

  // State register with asynchronous active-high clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      valid_q      <= 1'b0;
      wrap_pulse_q <= 1'b0;
      period_cnt_q <= '0;
      alarm_q      <= 1'b0;
      seq_err_q    <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      // NOTE: flops take non-blocking assignments. Every register then updates
      // from the values it held before the edge, whatever order the lines are in.
      count_q      <= count_d;
      valid_q      <= valid_d;
      wrap_pulse_q <= wrap_pulse_d;
      period_cnt_q <= period_cnt_d;
      alarm_q      <= alarm_d;
      seq_err_q    <= seq_err_d;
      state_q      <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wrap_pulse = wrap_pulse_q;
  assign period_cnt = period_cnt_q;
  assign alarm      = alarm_q;
  assign seq_err    = seq_err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_countdown_monitor.sv
// Bench for countdown_monitor (N=5, P=8, 10 ns clock).
// Three processes run alongside the main sequence:
//   - an upstream down counter that can take an injected jump or a stall,
//   - an integer reference model of the monitor,
//   - a compare process that checks every output against the model on each
//     falling edge.
// The main sequence walks the directed scenarios, pins key values with literal
// expectations, then ends with a randomized phase.

`timescale 1ns/1ps

module tb_countdown_monitor;

  localparam int N    = 5;
  localparam int P    = 8;
  localparam int CMOD = 1 << N;   // 32
  localparam int PMOD = 1 << P;   // 256

  logic         clk;
  logic         reset;
  logic [N-1:0] count_in;
  logic         arm;
  logic [P-1:0] threshold;
  logic         alarm_ack;
  logic         wrap_pulse;
  logic [P-1:0] period_cnt;
  logic         alarm;
  logic         seq_err;
  logic [1:0]   state;

  countdown_monitor #(.N(N), .P(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .arm        (arm),
    .threshold  (threshold),
    .alarm_ack  (alarm_ack),
    .wrap_pulse (wrap_pulse),
    .period_cnt (period_cnt),
    .alarm      (alarm),
    .seq_err    (seq_err),
    .state      (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Upstream counter. It steps 2 ns after each rising edge and keeps running
  // through reset. The main sequence asks for a jump or a stall through
  // request counters.
  // ---------------------------------------------------------------------------
  int           inj_req  = 0;
  int           hold_req = 0;
  logic [N-1:0] inj_val  = '0;

  initial begin
    int inj_seen  = 0;
    int hold_seen = 0;
    int hold_left = 0;
    count_in = 5'd7;
    forever begin
      @(posedge clk);
      #2;
      if (inj_req != inj_seen) begin
        inj_seen = inj_req;
        count_in = inj_val;
      end else begin
        if (hold_req != hold_seen) begin
          hold_seen = hold_req;
          hold_left = 2;
        end
        if (hold_left > 0) hold_left--;
        else count_in = count_in - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: plain integer bookkeeping.
  // m_mode is 0 idle, 1 armed, 2 alarm (the visible state code).
  // ---------------------------------------------------------------------------
  int m_prev      = 0;
  bit m_have_prev = 0;
  bit m_wrap      = 0;
  int m_period    = 0;
  int m_mode      = 0;
  bit m_seq       = 0;

  initial begin
    bit w;
    int cur;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_prev = 0; m_have_prev = 0; m_wrap = 0;
        m_period = 0; m_mode = 0; m_seq = 0;
      end else begin
        cur = int'(count_in);
        w   = m_have_prev && (m_prev == 0) && (cur == CMOD - 1);
        if (m_have_prev && (cur != (m_prev + CMOD - 1) % CMOD)) m_seq = 1;
        if (m_mode == 0) begin
          m_period = 0;
          if (arm) m_mode = 1;
        end else if (m_mode == 1) begin
          if (!arm) begin
            m_mode = 0; m_period = 0;
          end else if (w) begin
            m_period = (m_period + 1) % PMOD;
            if (threshold != 0 && m_period == int'(threshold)) m_mode = 2;
          end
        end else begin
          if (alarm_ack) begin
            m_period = 0;
            m_mode   = arm ? 1 : 0;
          end
        end
        m_wrap      = w;
        m_prev      = cur;
        m_have_prev = 1;
      end
    end
  end

  // Compare every output with the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("wrap_pulse", wrap_pulse, m_wrap);
      check("period_cnt", period_cnt, m_period);
      check("alarm",      alarm,      (m_mode == 2));
      check("seq_err",    seq_err,    m_seq);
      check("state",      state,      m_mode);
    end
  end

  // Watchdog
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic wait_count(input logic [N-1:0] v, input int limit, input string name);
    bit found = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (count_in == v) begin
        found = 1;
        break;
      end
    end
    check(name, found, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    #3 reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int pulses;
    bit found;

    arm = 1'b0; threshold = '0; alarm_ack = 1'b0; reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_wrap_pulse", wrap_pulse, 0);
    check("rst_period_cnt", period_cnt, 0);
    check("rst_alarm",      alarm,      0);
    check("rst_seq_err",    seq_err,    0);
    check("rst_state",      state,      0);
    #18 reset = 1'b0;

    // 1: free run, disarmed. One pulse every 32 cycles.
    repeat (3) @(negedge clk);
    pulses = 0;
    repeat (64) begin
      @(negedge clk);
      if (wrap_pulse) pulses++;
    end
    check("t1_pulses_in_64", pulses, 2);
    check("t1_period_cnt", period_cnt, 0);
    check("t1_seq_err", seq_err, 0);
    check("t1_state_idle", state, 2'b00);

    // 2: arm with threshold 3. Alarm comes with the third wrap pulse.
    wait_count(5'd16, 40, "t2_wait_count16");
    threshold = 8'd3;
    arm       = 1'b1;
    pulses    = 0;
    found     = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wrap_pulse) pulses++;
      if (alarm) begin
        found = 1;
        break;
      end
    end
    check("t2_alarm_seen", found, 1);
    check("t2_pulses_at_alarm", pulses, 3);
    check("t2_pulse_with_alarm", wrap_pulse, 1);
    check("t2_state_alarm", state, 2'b10);
    check("t2_period_3", period_cnt, 3);
    repeat (70) @(negedge clk);
    check("t2_period_held", period_cnt, 3);
    check("t2_alarm_held", alarm, 1);

    // 3a: ack away from any wrap
    wait_count(5'd10, 40, "t3_wait_count10");
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    check("t3a_alarm", alarm, 0);
    check("t3a_state", state, 2'b01);
    check("t3a_period", period_cnt, 0);

    // 3b: alarm again, then ack on a wrap edge
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (alarm) begin
        found = 1;
        break;
      end
    end
    check("t3b_alarm_again", found, 1);
    wait_count('1, 40, "t3b_wait_count31");
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    check("t3b_wrap_pulse", wrap_pulse, 1);
    check("t3b_alarm", alarm, 0);
    check("t3b_state", state, 2'b01);
    check("t3b_period", period_cnt, 0);

    // 5: reset while ARMED with period_cnt = 2. The release is timed so the
    //    first sample is all-ones, which would look like a wrap from a cleared
    //    count_q.
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_period == 2 && m_mode == 1) begin
        found = 1;
        break;
      end
    end
    check("t5_reach_period2", found, 1);
    check("t5_period_before", period_cnt, 2);
    #3 reset = 1'b1;
    #1;
    check("t5_async_wrap_pulse", wrap_pulse, 0);
    check("t5_async_period_cnt", period_cnt, 0);
    check("t5_async_alarm",      alarm,      0);
    check("t5_async_seq_err",    seq_err,    0);
    check("t5_async_state",      state,      0);
    wait_count('1, 40, "t5_wait_count31");
    #3 reset = 1'b0;
    @(negedge clk);
    check("t5_first_no_wrap", wrap_pulse, 0);
    check("t5_first_no_seq", seq_err, 0);
    repeat (40) @(negedge clk);

    // 4: sequence errors, a jump and then a stall
    arm = 1'b0;
    wait_count(5'd20, 40, "t4_wait_count20");
    inj_val = 5'd17;
    inj_req++;
    repeat (2) @(negedge clk);
    check("t4_jump_seq_err", seq_err, 1);
    repeat (20) @(negedge clk);
    check("t4_jump_sticky", seq_err, 1);
    do_reset();
    repeat (2) @(negedge clk);
    check("t4_clear_after_reset", seq_err, 0);
    wait_count(5'd9, 40, "t4_wait_count9");
    hold_req++;
    repeat (3) @(negedge clk);
    check("t4_stall_seq_err", seq_err, 1);
    repeat (10) @(negedge clk);
    check("t4_stall_sticky", seq_err, 1);
    do_reset();
    repeat (2) @(negedge clk);
    check("t4_clear_again", seq_err, 0);

    // 6: threshold 0 never alarms, and period_cnt rolls over mod 256
    threshold = '0;
    repeat (2) @(negedge clk);
    wait_count(5'd16, 40, "t6_wait_count16");
    arm = 1'b1;
    repeat (255 * 32) @(negedge clk);
    check("t6_period_255", period_cnt, 255);
    check("t6_no_alarm_255", alarm, 0);
    repeat (32) @(negedge clk);
    check("t6_period_0", period_cnt, 0);
    repeat (4 * 32) @(negedge clk);
    check("t6_period_4", period_cnt, 4);
    check("t6_no_alarm", alarm, 0);
    check("t6_state_armed", state, 2'b01);

    // Random phase: arm toggles, stray acks, small thresholds, rare jumps
    do_reset();
    threshold = 8'd2;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) arm = ~arm;
      alarm_ack = ($urandom_range(0, 15) == 0);
      if (!arm && m_mode == 0 && $urandom_range(0, 9) == 0)
        threshold = P'($urandom_range(0, 3));
      if ($urandom_range(0, 799) == 0) begin
        inj_val = N'($urandom_range(0, CMOD - 1));
        inj_req++;
      end
    end
    alarm_ack = 1'b0;
    arm       = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
